// File: rtl/bit_count_accum.sv
// bit_count_accum
//   Counts ones (or zeros) in each accepted input word and accumulates the
//   counts over a frame terminated by in_last. The frame total is then held
//   on out_count/out_sat until the consumer accepts it.
//
//   Pipeline: stage 1 registers the per-word count and last flag, and
//   stage 2 adds the registered count into a saturating accumulator.
//   FSM:      ACCUM (accepting words) -> DRAIN (final count lands)
//             -> HOLD (result valid) -> ACCUM.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake
//   in_data [WIDTH]   word to count
//   in_last           final word of the frame
//   count_zeros       0: count ones, 1: count zeros (per word)
//   out_valid/out_ready result handshake
//   out_count [CNT_W] frame total (running total while in ACCUM)
//   out_sat           frame total saturated
module bit_count_accum #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             count_zeros,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);
    localparam int PW = $clog2(WIDTH + 1);
    // Sum width covers either operand plus a carry so overflow is visible
    // even when the per-word count is wider than the accumulator.
    localparam int SW = ((PW > CNT_W) ? PW : CNT_W) + 1;
    localparam logic [CNT_W-1:0] MAXV = '1;

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   pc, wcnt;
    logic            accept;
    logic            s1_vld, s1_last;
    logic [PW-1:0]   s1_cnt;
    logic [CNT_W-1:0] acc;
    logic            sat;
    logic [SW-1:0]   sum;
    logic            over;

    // Word count (stage 1 input)
    always_comb begin
        pc = '0;
        for (int i = 0; i < WIDTH; i++) pc = pc + PW'(in_data[i]);
        wcnt = count_zeros ? (PW'(WIDTH) - pc) : pc;
    end

    // While reset is held the block presents its idle face regardless of state.
    assign in_ready  = rst || (state == ACCUM);
    assign accept    = in_valid && in_ready;
    assign out_valid = !rst && (state == HOLD);
    assign out_count = rst ? '0 : acc;
    assign out_sat   = !rst && sat;

    assign sum  = SW'(acc) + SW'(s1_cnt);
    assign over = sum > SW'(MAXV);

    always_comb begin
        state_nx = state;
        case (state)
            ACCUM:   if (in_valid && in_last) state_nx = DRAIN;
            // The last word is always in stage 1 here; it lands this cycle.
            DRAIN:   if (s1_vld && s1_last)   state_nx = HOLD;
            HOLD:    if (out_ready)           state_nx = ACCUM;
            default:                          state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ACCUM;
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_cnt  <= '0;
            acc     <= '0;
            sat     <= 1'b0;
        end else begin
            state  <= state_nx;
            s1_vld <= accept;
            if (accept) begin
                s1_cnt  <= wcnt;
                s1_last <= in_last;
            end
            if (state == HOLD && out_ready) begin
                acc <= '0;
                sat <= 1'b0;
            end else if (s1_vld) begin
                acc <= over ? MAXV : sum[CNT_W-1:0];
                sat <= sat | over;
            end
        end
    end
endmodule
